// File: rtl/move_select_input.sv
// Debounce/synchroniser front end for the move and select push-buttons.
// Optional move auto-repeat is built only when MOVE_AUTOREPEAT_EN is defined.

module move_select_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
`ifdef MOVE_AUTOREPEAT_EN
    ,
    parameter bit REPEAT          = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic held,
    output logic accept
`ifdef MOVE_AUTOREPEAT_EN
    ,
    output logic rpt
`endif
);
    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    // The D-th consecutive stable sample lands on LAST; the counter is then cleared by the state change.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       sync;
    logic             smp, held_nxt, accept_nxt;

    assign smp = sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync   <= 2'b11;
            state  <= RELEASED;
            cnt    <= '0;
            held   <= 1'b0;
            accept <= 1'b0;
        end else begin
            sync   <= {sync[0], key_n};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            held   <= held_nxt;
            accept <= accept_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RELEASED: if (!smp) begin
                state_nxt = PRESS_WAIT;
                cnt_nxt   = ONE;
            end
            PRESS_WAIT: begin
                if (smp) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            PRESSED: if (smp) begin
                state_nxt = RELEASE_WAIT;
                cnt_nxt   = ONE;
            end
            default: begin
                if (!smp) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
        endcase
    end

    always_comb begin
        accept_nxt = (state == PRESS_WAIT) && (state_nxt == PRESSED);
        held_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    end

`ifdef MOVE_AUTOREPEAT_EN
    generate
        if (REPEAT) begin : g_rpt
            localparam int RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RPT_W = $clog2(RMAX + 1);
            localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
            localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

            logic [RPT_W-1:0] rpt_cnt;
            logic             first;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rpt_cnt <= '0;
                    first   <= 1'b1;
                    rpt     <= 1'b0;
                end else if (state == PRESSED) begin
                    if (rpt_cnt == (first ? DLY_LAST : PER_LAST)) begin
                        rpt_cnt <= '0;
                        first   <= 1'b0;
                        rpt     <= 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + RPT_W'(1);
                        rpt     <= 1'b0;
                    end
                end else begin
                    rpt_cnt <= '0;
                    first   <= 1'b1;
                    rpt     <= 1'b0;
                end
            end
        end else begin : g_no_rpt
            assign rpt = 1'b0;
        end
    endgenerate
`endif
endmodule

module move_select_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
`ifdef MOVE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_move_n,
    input  logic key_select_n,
    input  logic lock,
    output logic move,
    output logic select,
    output logic move_held,
    output logic select_held
);
    logic acc_move, acc_select, ev_move, ev_select;

`ifdef MOVE_AUTOREPEAT_EN
    logic rpt_move, rpt_select;

    move_select_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .REPEAT(1'b1),
                          .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_move (
        .clk(clk), .rst(rst), .key_n(key_move_n), .held(move_held), .accept(acc_move), .rpt(rpt_move));
    move_select_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .REPEAT(1'b0),
                          .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_select (
        .clk(clk), .rst(rst), .key_n(key_select_n), .held(select_held), .accept(acc_select), .rpt(rpt_select));

    assign ev_move   = acc_move | rpt_move;
    assign ev_select = acc_select | rpt_select;
`else
    move_select_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_move (
        .clk(clk), .rst(rst), .key_n(key_move_n), .held(move_held), .accept(acc_move));
    move_select_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_select (
        .clk(clk), .rst(rst), .key_n(key_select_n), .held(select_held), .accept(acc_select));

    assign ev_move   = acc_move;
    assign ev_select = acc_select;
`endif

    // Select wins a tie; the losing move event is dropped, not deferred.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move   <= 1'b0;
            select <= 1'b0;
        end else begin
            move   <= ev_move & ~lock & ~ev_select;
            select <= ev_select & ~lock;
        end
    end
endmodule
